shift_seq: RTL
==============

SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001 Parameter: DATA_WIDTH, default 16, operand width in bits (>= 4).
REQ-002 Parameter: CNT_WIDTH, default 5, shift-count width in bits; legal counts are 0 .. 2^CNT_WIDTH-1.
REQ-003 Ports: clk  in  1  sole clock, all state updates on its rising edge.
REQ-004 Ports: rst_n  in  1  reset, synchronous and active-low.
REQ-005 Ports: startIn  in  1  request to begin a multi-bit shift.
REQ-006 Ports: op  in  2  operation select: 0 SHL-through-carry, 1 SHR-through-carry, 2 ASR, 3 ROL.
REQ-007 Ports: count  in  CNT_WIDTH  number of single-bit steps.
REQ-008 Ports: carryIn  in  1  initial carry.
REQ-009 Ports: LhsIn  in  DATA_WIDTH  operand.
REQ-010 Ports: flush  in  1  pipeline flush, aborts any operation in flight.
REQ-011 Ports: ready  out  1  high only in IDLE, meaning a request will be accepted.
REQ-012 Ports: done  out  1  one-cycle pulse marking a valid result.
REQ-013 Ports: LhsOut  out  DATA_WIDTH  result/working register.
REQ-014 Ports: carryOut  out  1  result/working carry.

Function
REQ-015 FSM states: IDLE, SHIFT, DONE.
REQ-016 Acceptance: startIn=1 and ready=1 at edge E0 latches LhsIn, carryIn, op and count, and moves the FSM to SHIFT with remaining=count.
REQ-017 startIn while ready=0 is ignored, with no queuing.
REQ-018 SHIFT with remaining>0: each cycle performs one step and decrements remaining.
REQ-019 SHIFT step SHL: carry<=data[MSB]; data<={data[MSB-1:0],carry}.
REQ-020 SHIFT step SHR: carry<=data[0]; data<={carry,data[MSB:1]}.
REQ-021 SHIFT step ASR: carry<=data[0]; data<={data[MSB],data[MSB:1]}.
REQ-022 SHIFT step ROL: carry<=data[MSB]; data<={data[MSB-1:0],data[MSB]}.
REQ-023 SHIFT exit: the edge performing the last step (or, for count=0, the first SHIFT edge, which performs no step) moves the FSM to DONE.
REQ-024 Latency: done is high for exactly the one cycle following edge E0+max(count,1).
REQ-025 DONE returns to IDLE on the next edge, so ready rises one cycle after done.
REQ-026 LhsOut/carryOut hold the final result from done until the next acceptance; intermediate values during SHIFT are visible but not valid.
REQ-027 count=0: LhsOut=LhsIn and carryOut=carryIn at done.
REQ-028 count>=DATA_WIDTH is legal and iterates fully; no clamping.
REQ-029 flush=1 in SHIFT or DONE: the FSM goes to IDLE on the next edge, done stays 0, and LhsOut/carryOut keep their current values.
REQ-030 flush and startIn both high in IDLE: flush wins and the request is dropped.
REQ-031 op and count changing after acceptance have no effect on the operation in flight.

Reset
REQ-032 rst_n=0 at an edge forces: IDLE, ready=1, done=0, LhsOut=0, carryOut=0, remaining=0.
REQ-033 Reset mid-operation discards the operation with no done pulse; reset has priority over flush and startIn.

Configuration
REQ-034 Macro SHIFT_SEQ_ZERO_FLAG_EN: when defined, the block adds output zeroOut (1 bit).
REQ-035 With SHIFT_SEQ_ZERO_FLAG_EN defined, zeroOut is registered, updates with the result, equals (LhsOut==0) whenever done=1, and resets to 0.
REQ-036 Without SHIFT_SEQ_ZERO_FLAG_EN, the port and its logic are absent and all other behaviour is identical.

Structure
REQ-037 Shared package: op encodings (SHL/SHR/ASR/ROL) and the FSM state typedef, shared with the existing single-step shift stage.
REQ-038 Sub-module shift_step: the combinational one-bit step {op,data,carry}->{data,carry}; the sequencer instantiates it once.

Verification (DATA_WIDTH=16)
REQ-039 SHL chain: op=0, LhsIn=0x8001, carryIn=1, count=4 -> done 4 cycles after accept, LhsOut=0x001C, carryOut=0.
REQ-040 SHR to zero: op=1, LhsIn=0x0001, carryIn=0, count=1 -> LhsOut=0x0000, carryOut=1, zeroOut=1 when enabled.
REQ-041 ASR and zero count: op=2, LhsIn=0x8000, count=3 -> LhsOut=0xF000, carryOut=0; separately count=0, LhsIn=0xA5A5, carryIn=1 -> LhsOut=0xA5A5, carryOut=1, done 1 cycle after accept.
REQ-042 ROL full turn and busy request: op=3, LhsIn=0x1234, count=16 -> LhsOut=0x1234, carryOut=0; a second startIn issued while busy is ignored.
REQ-043 flush and reset: flush at step 2 of count=8 -> no done, ready=1 next cycle; rst_n=0 mid-SHIFT -> LhsOut=0, carryOut=0, ready=1, no done.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared definitions for the multi-bit shift sequencer and its single-step shift stage.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        OP_SHL = 2'd0,
        OP_SHR = 2'd1,
        OP_ASR = 2'd2,
        OP_ROL = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/shift_seq_step.sv
// Combinational one-bit shift step: {op, data, carry} -> {data, carry}.
module shift_step
    import shift_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  op_e                   op,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  carry_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  carry_out
);

    // Single-bit step for each operation; SHL/SHR rotate through the carry bit.
    always_comb begin
        data_out  = data_in;
        carry_out = carry_in;
        case (op)
            OP_SHL: begin
                carry_out = data_in[DATA_WIDTH-1];
                data_out  = {data_in[DATA_WIDTH-2:0], carry_in};
            end
            OP_SHR: begin
                carry_out = data_in[0];
                data_out  = {carry_in, data_in[DATA_WIDTH-1:1]};
            end
            OP_ASR: begin
                carry_out = data_in[0];
                data_out  = {data_in[DATA_WIDTH-1], data_in[DATA_WIDTH-1:1]};
            end
            OP_ROL: begin
                carry_out = data_in[DATA_WIDTH-1];
                data_out  = {data_in[DATA_WIDTH-2:0], data_in[DATA_WIDTH-1]};
            end
            default: begin
                data_out  = data_in;
                carry_out = carry_in;
            end
        endcase
    end

endmodule

// File: rtl/shift_seq.sv
// Multi-bit shift sequencer: iterates shift_step once per cycle for 'count' steps.
// Optional zero-result flag output zeroOut enabled by defining SHIFT_SEQ_ZERO_FLAG_EN.
module shift_seq
    import shift_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  startIn,
    input  logic [1:0]            op,
    input  logic [CNT_WIDTH-1:0]  count,
    input  logic                  carryIn,
    input  logic [DATA_WIDTH-1:0] LhsIn,
    input  logic                  flush,
    output logic                  ready,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] LhsOut,
    output logic                  carryOut
`ifdef SHIFT_SEQ_ZERO_FLAG_EN
    ,
    output logic                  zeroOut
`endif
);

    state_e                  state_q, state_d;
    op_e                     op_q, op_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    carry_q, carry_d;
    logic [CNT_WIDTH-1:0]    rem_q, rem_d;
    logic                    ready_q, ready_d;
    logic                    done_q, done_d;
    logic [DATA_WIDTH-1:0]   step_data_s;
    logic                    step_carry_s;

    shift_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .op        (op_q),
        .data_in   (data_q),
        .carry_in  (carry_q),
        .data_out  (step_data_s),
        .carry_out (step_carry_s)
    );

    // Next-state, working register and registered handshake computation.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        carry_d = carry_q;
        rem_d   = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (startIn && !flush) begin
                    op_d    = op_e'(op);
                    data_d  = LhsIn;
                    carry_d = carryIn;
                    rem_d   = count;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (rem_q != {CNT_WIDTH{1'b0}}) begin
                    data_d  = step_data_s;
                    carry_d = step_carry_s;
                    rem_d   = rem_q - {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                    if (rem_q == {{(CNT_WIDTH-1){1'b0}}, 1'b1}) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ready_d = (state_d == ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_SHL;
            data_q  <= {DATA_WIDTH{1'b0}};
            carry_q <= 1'b0;
            rem_q   <= {CNT_WIDTH{1'b0}};
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            carry_q <= carry_d;
            rem_q   <= rem_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign ready    = ready_q;
    assign done     = done_q;
    assign LhsOut   = data_q;
    assign carryOut = carry_q;

`ifdef SHIFT_SEQ_ZERO_FLAG_EN
    logic zero_q, zero_d;

    // Zero flag captured together with the final result.
    always_comb begin
        if (state_d == ST_DONE) begin
            zero_d = (data_d == {DATA_WIDTH{1'b0}});
        end else begin
            zero_d = zero_q;
        end
    end

    // Zero flag register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
        end else begin
            zero_q <= zero_d;
        end
    end

    assign zeroOut = zero_q;
`endif

endmodule
